// File: rtl/mips_core_pkg.sv
// ---------------------------------------------------------------------------
// mips_core_pkg
// Shared types and constants for the rename / retire path of the core.
//   AL_DEPTH_DEFAULT : default number of active-list entries (power of two)
//   AL_PHYS_W        : physical register index width
//   AL_ARCH_W        : architectural register index width
//   ActiveListEntry  : one active-list slot (valid, done, arch, old_phys, new_phys)
//   AlRetireState    : retire FSM states (normal running / squash walk-back)
// ---------------------------------------------------------------------------
package mips_core_pkg;

    localparam int AL_DEPTH_DEFAULT = 32;
    localparam int AL_PHYS_W        = 6;
    localparam int AL_ARCH_W        = 5;

    typedef struct packed {
        logic                 valid;
        logic                 done;
        logic [AL_ARCH_W-1:0] arch;
        logic [AL_PHYS_W-1:0] old_phys;
        logic [AL_PHYS_W-1:0] new_phys;
    } ActiveListEntry;

    typedef enum logic {
        AL_RUN,
        AL_WALK
    } AlRetireState;

endpackage

// File: rtl/active_list_ram.sv
// ---------------------------------------------------------------------------
// active_list_ram
// Storage for the active list: AL_DEPTH entries with one write port (push),
// one done-set port (writeback), one invalidate port (commit or walk-back pop)
// and two combinational read ports (head entry, new_phys of tail-1).
//   clk, rst_n          : clock, asynchronous active-low reset (clears valid/done)
//   wr_en_i .. wr_*_i   : push a new entry at wr_idx_i (valid=1, done=0)
//   done_en_i/idx_i     : mark an entry done, ignored if the entry is not valid
//   inv_en_i/idx_i      : invalidate an entry
//   head_idx_i          : read address for the head entry -> head_entry_o
//   tail_rd_idx_i       : read address for tail-1 -> tail_new_phys_o
// ---------------------------------------------------------------------------
module active_list_ram
    import mips_core_pkg::*;
#(
    parameter int AL_DEPTH = AL_DEPTH_DEFAULT,
    parameter int IDX_W    = $clog2(AL_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en_i,
    input  logic [IDX_W-1:0]     wr_idx_i,
    input  logic [AL_ARCH_W-1:0] wr_arch_i,
    input  logic [AL_PHYS_W-1:0] wr_old_phys_i,
    input  logic [AL_PHYS_W-1:0] wr_new_phys_i,
    input  logic                 done_en_i,
    input  logic [IDX_W-1:0]     done_idx_i,
    input  logic                 inv_en_i,
    input  logic [IDX_W-1:0]     inv_idx_i,
    input  logic [IDX_W-1:0]     head_idx_i,
    input  logic [IDX_W-1:0]     tail_rd_idx_i,
    output ActiveListEntry       head_entry_o,
    output logic [AL_PHYS_W-1:0] tail_new_phys_o
);

    logic [AL_DEPTH-1:0]  valid_q;
    logic [AL_DEPTH-1:0]  done_q;
    logic [AL_ARCH_W-1:0] arch_q     [AL_DEPTH];
    logic [AL_PHYS_W-1:0] old_phys_q [AL_DEPTH];
    logic [AL_PHYS_W-1:0] new_phys_q [AL_DEPTH];

    // Status bits. Later statements win: a writeback racing an invalidate
    // leaves the slot empty, and a push always starts a slot not-done.
    // A writeback checks the pre-edge valid bit, so it can never hit the
    // slot being pushed in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            done_q  <= '0;
        end else begin
            if (done_en_i && valid_q[done_idx_i]) begin
                done_q[done_idx_i] <= 1'b1;
            end
            if (inv_en_i) begin
                valid_q[inv_idx_i] <= 1'b0;
                done_q[inv_idx_i]  <= 1'b0;
            end
            if (wr_en_i) begin
                valid_q[wr_idx_i] <= 1'b1;
                done_q[wr_idx_i]  <= 1'b0;
            end
        end
    end

    // Payload needs no reset; it is only looked at while valid is set.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            arch_q[wr_idx_i]     <= wr_arch_i;
            old_phys_q[wr_idx_i] <= wr_old_phys_i;
            new_phys_q[wr_idx_i] <= wr_new_phys_i;
        end
    end

    // Combinational read ports.
    always_comb begin
        head_entry_o.valid    = valid_q[head_idx_i];
        head_entry_o.done     = done_q[head_idx_i];
        head_entry_o.arch     = arch_q[head_idx_i];
        head_entry_o.old_phys = old_phys_q[head_idx_i];
        head_entry_o.new_phys = new_phys_q[head_idx_i];
        tail_new_phys_o       = new_phys_q[tail_rd_idx_i];
    end

endmodule

// File: rtl/active_list_retire.sv
// ---------------------------------------------------------------------------
// active_list_retire
// In-order retire end of the rename path. Entries are pushed at the tail,
// marked done by writeback, and committed in order from the head (old phys
// reg returned to the free list). On a mispredict a walk-back pops squashed
// entries from the tail one per cycle, freeing their new phys regs.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   alloc_valid/arch/old/new   : push request from the renamer
//   alloc_ready, alloc_idx     : push accepted / slot assigned (combinational)
//   wb_valid, wb_idx           : writeback completion
//   squash_valid, squash_idx   : squash this entry and everything younger
//   free_valid, free_phys      : phys reg returned (registered)
//   commit_valid/arch/phys     : retired mapping (registered)
//   busy                       : walk-back in progress
// Optional: define AL_RETIRE_STATS_EN to add stat_commits / stat_squashed.
// ---------------------------------------------------------------------------
module active_list_retire
    import mips_core_pkg::*;
#(
    parameter int AL_DEPTH = AL_DEPTH_DEFAULT,
    parameter int PHYS_W   = AL_PHYS_W,
    parameter int ARCH_W   = AL_ARCH_W,
    parameter int IDX_W    = $clog2(AL_DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alloc_valid,
    input  logic [ARCH_W-1:0] alloc_arch,
    input  logic [PHYS_W-1:0] alloc_old_phys,
    input  logic [PHYS_W-1:0] alloc_new_phys,
    output logic              alloc_ready,
    output logic [IDX_W-1:0]  alloc_idx,
    input  logic              wb_valid,
    input  logic [IDX_W-1:0]  wb_idx,
    input  logic              squash_valid,
    input  logic [IDX_W-1:0]  squash_idx,
    output logic              free_valid,
    output logic [PHYS_W-1:0] free_phys,
    output logic              commit_valid,
    output logic [ARCH_W-1:0] commit_arch,
    output logic [PHYS_W-1:0] commit_phys,
    output logic              busy
`ifdef AL_RETIRE_STATS_EN
    ,
    output logic [31:0]       stat_commits,
    output logic [31:0]       stat_squashed
`endif
);

    localparam int PTR_W = IDX_W + 1;

    AlRetireState   state_q, state_d;
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d, target_q, target_d;
    logic [PTR_W-1:0] count, tail_dec, sq_target, tgt_offset;
    logic [IDX_W-1:0] sq_offset;
    logic             empty, full, sq_live, sq_older;
    logic             squash_take, push, do_commit, walk_pop, inv_en;
    logic [IDX_W-1:0] inv_idx;
    ActiveListEntry   head_entry;
    logic [PHYS_W-1:0] tail_new_phys;

    logic              commit_valid_q, commit_valid_d, free_valid_q, free_valid_d;
    logic [ARCH_W-1:0] commit_arch_q, commit_arch_d;
    logic [PHYS_W-1:0] commit_phys_q, commit_phys_d, free_phys_q, free_phys_d;

    // Pointer arithmetic. A squash index is live when its distance from the
    // head is below the count; adding that distance to the full head pointer
    // yields a target that carries the correct wrap bit.
    assign count      = tail_q - head_q;
    assign empty      = (count == '0);
    assign full       = (count == PTR_W'(AL_DEPTH));
    assign tail_dec   = tail_q - PTR_W'(1);
    assign sq_offset  = squash_idx - head_q[IDX_W-1:0];
    assign sq_live    = ({1'b0, sq_offset} < count);
    assign sq_target  = head_q + {1'b0, sq_offset};
    assign tgt_offset = target_q - head_q;
    assign sq_older   = sq_live && ({1'b0, sq_offset} < tgt_offset);

    active_list_ram #(
        .AL_DEPTH (AL_DEPTH),
        .IDX_W    (IDX_W)
    ) u_ram (
        .clk             (clk),
        .rst_n           (rst_n),
        .wr_en_i         (push),
        .wr_idx_i        (tail_q[IDX_W-1:0]),
        .wr_arch_i       (alloc_arch),
        .wr_old_phys_i   (alloc_old_phys),
        .wr_new_phys_i   (alloc_new_phys),
        .done_en_i       (wb_valid),
        .done_idx_i      (wb_idx),
        .inv_en_i        (inv_en),
        .inv_idx_i       (inv_idx),
        .head_idx_i      (head_q[IDX_W-1:0]),
        .tail_rd_idx_i   (tail_dec[IDX_W-1:0]),
        .head_entry_o    (head_entry),
        .tail_new_phys_o (tail_new_phys)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= AL_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state. In WALK a newer squash may only pull the target
    // towards the head; the exit test uses the possibly-updated target so a
    // late older squash keeps the walk going.
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        case (state_q)
            AL_RUN: begin
                if (squash_valid && sq_live) begin
                    state_d  = AL_WALK;
                    target_d = sq_target;
                end
            end
            AL_WALK: begin
                if (squash_valid && sq_older) begin
                    target_d = sq_target;
                end
                if (tail_dec == target_d) begin
                    state_d = AL_RUN;
                end
            end
            default: state_d = AL_RUN;
        endcase
    end

    // FSM outputs and datapath control. An accepted squash blocks push and
    // commit that cycle; alloc_ready deliberately ignores a same-cycle commit.
    always_comb begin
        alloc_ready    = (state_q == AL_RUN) && !full;
        alloc_idx      = tail_q[IDX_W-1:0];
        busy           = (state_q == AL_WALK);
        squash_take    = (state_q == AL_RUN) && squash_valid && sq_live;
        push           = alloc_valid && alloc_ready && !squash_take;
        do_commit      = (state_q == AL_RUN) && !squash_take && !empty
                         && head_entry.valid && head_entry.done;
        walk_pop       = (state_q == AL_WALK);
        head_d         = head_q + PTR_W'(do_commit);
        tail_d         = walk_pop ? tail_dec : (tail_q + PTR_W'(push));
        inv_en         = do_commit || walk_pop;
        inv_idx        = walk_pop ? tail_dec[IDX_W-1:0] : head_q[IDX_W-1:0];
        commit_valid_d = do_commit;
        commit_arch_d  = do_commit ? head_entry.arch : commit_arch_q;
        commit_phys_d  = do_commit ? head_entry.new_phys : commit_phys_q;
        free_valid_d   = do_commit || walk_pop;
        free_phys_d    = walk_pop ? tail_new_phys
                       : (do_commit ? head_entry.old_phys : free_phys_q);
    end

    // Pointers, walk target and registered retire/free outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q         <= '0;
            tail_q         <= '0;
            target_q       <= '0;
            commit_valid_q <= 1'b0;
            commit_arch_q  <= '0;
            commit_phys_q  <= '0;
            free_valid_q   <= 1'b0;
            free_phys_q    <= '0;
        end else begin
            head_q         <= head_d;
            tail_q         <= tail_d;
            target_q       <= target_d;
            commit_valid_q <= commit_valid_d;
            commit_arch_q  <= commit_arch_d;
            commit_phys_q  <= commit_phys_d;
            free_valid_q   <= free_valid_d;
            free_phys_q    <= free_phys_d;
        end
    end

    assign commit_valid = commit_valid_q;
    assign commit_arch  = commit_arch_q;
    assign commit_phys  = commit_phys_q;
    assign free_valid   = free_valid_q;
    assign free_phys    = free_phys_q;

`ifdef AL_RETIRE_STATS_EN
    logic [31:0] stat_commits_q, stat_squashed_q;

    // Event counters, wrapping naturally at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_commits_q  <= '0;
            stat_squashed_q <= '0;
        end else begin
            stat_commits_q  <= stat_commits_q + 32'(do_commit);
            stat_squashed_q <= stat_squashed_q + 32'(walk_pop);
        end
    end

    assign stat_commits  = stat_commits_q;
    assign stat_squashed = stat_squashed_q;
`endif

    // Pushing into a list that cannot accept is a renamer protocol error.
    a_push_when_not_ready: assert property (
        @(posedge clk) disable iff (!rst_n) !(alloc_valid && !alloc_ready)
    );

endmodule
